// File: rtl/r200ex_seq.sv
// r200ex_seq - execute stage of the r200 core.
//
// Takes decoded RV32I/M operands and produces a registered ALU result,
// branch decision and jump target. Base ALU, branch and jump operations
// take one cycle. MUL/MULH/MULHSU/MULHU use an iterative shift-add unit.
// Valid/ready handshakes are used on both sides, and a flush input kills
// any in-flight or held operation.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   flush               synchronous kill of in-flight/held op
//   in_valid/in_ready   input handshake
//   op1, op2, pc, imm   operands, instruction address, immediate
//   func3, alu_cont     instr[14:12], instr[30]
//   is_branch/is_jal/is_jalr/is_mul   op class (all zero = ALU op)
//   out_valid/out_ready output handshake
//   alu_res             ALU/multiply result, or pc+4 for jal/jalr
//   branch_taken        redirect required
//   jump_targ           redirect target
//   out_illegal         unsupported op (alu_res = 0)
module r200ex_seq #(
    parameter int XLEN   = 32,
    parameter int MUL_EN = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [2:0]      func3,
    input  logic            alu_cont,
    input  logic            is_branch,
    input  logic            is_jal,
    input  logic            is_jalr,
    input  logic            is_mul,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_res,
    output logic            branch_taken,
    output logic [XLEN-1:0] jump_targ,
    output logic            out_illegal
);

    localparam int SHW = $clog2(XLEN);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic [1:0]        r_state;
    logic [SHW-1:0]    r_cnt;
    logic              r_fix_ph;
    logic              r_neg;
    logic              r_hi;
    logic [XLEN-1:0]   r_mcand;
    logic [2*XLEN-1:0] r_prod;
    logic              r_out_valid;
    logic              r_branch_taken;
    logic              r_illegal;
    logic [XLEN-1:0]   r_alu_res;
    logic [XLEN-1:0]   r_jump_targ;

    logic [SHW-1:0]    w_shamt;
    logic              w_lt;
    logic              w_ltu;
    logic              w_eq;
    logic [XLEN-1:0]   w_alu;
    logic              w_br_taken;
    logic              w_br_bad;
    logic              w_mul_legal;
    logic              w_illegal;
    logic [XLEN-1:0]   w_res;
    logic [XLEN-1:0]   w_targ;
    logic              w_take;
    logic [XLEN-1:0]   w_jsum;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic [XLEN:0]     w_sum;
    logic [2*XLEN-1:0] w_step;
    logic [2*XLEN-1:0] w_fixed;
    logic [XLEN-1:0]   w_mul_out;
    logic              w_accept;

    assign w_shamt = op2[SHW-1:0];
    assign w_lt    = $signed(op1) < $signed(op2);
    assign w_ltu   = op1 < op2;
    assign w_eq    = op1 == op2;
    assign w_jsum  = op1 + imm;

    always_comb begin
        w_alu = '0;
        case (func3)
            3'b000: w_alu = alu_cont ? (op1 - op2) : (op1 + op2);
            3'b001: w_alu = op1 << w_shamt;
            3'b010: w_alu = {{(XLEN-1){1'b0}}, w_lt};
            3'b011: w_alu = {{(XLEN-1){1'b0}}, w_ltu};
            3'b100: w_alu = op1 ^ op2;
            3'b101: w_alu = alu_cont ? $unsigned($signed(op1) >>> w_shamt) : (op1 >> w_shamt);
            3'b110: w_alu = op1 | op2;
            default: w_alu = op1 & op2;
        endcase
    end

    always_comb begin
        w_br_taken = 1'b0;
        w_br_bad   = 1'b0;
        case (func3)
            3'b000: w_br_taken = w_eq;
            3'b001: w_br_taken = ~w_eq;
            3'b100: w_br_taken = w_lt;
            3'b101: w_br_taken = ~w_lt;
            3'b110: w_br_taken = w_ltu;
            3'b111: w_br_taken = ~w_ltu;
            default: w_br_bad = 1'b1;
        endcase
    end

    assign w_mul_legal = is_mul & (MUL_EN != 0) & ~func3[2];
    assign w_illegal   = (is_branch & w_br_bad) | (is_mul & ~w_mul_legal);

    always_comb begin
        w_res  = '0;
        w_targ = '0;
        w_take = 1'b0;
        if (w_illegal) begin
            w_res = '0;
        end else if (is_jal) begin
            w_res  = pc + PC_STEP;
            w_targ = pc + imm;
            w_take = 1'b1;
        end else if (is_jalr) begin
            w_res  = pc + PC_STEP;
            w_targ = {w_jsum[XLEN-1:1], 1'b0};
            w_take = 1'b1;
        end else if (is_branch) begin
            w_targ = pc + imm;
            w_take = w_br_taken;
        end else begin
            w_res = w_alu;
        end
    end

    // op1 is signed for MULH (01) and MULHSU (10); op2 only for MULH.
    assign w_a_neg = (func3[1] ^ func3[0]) & op1[XLEN-1];
    assign w_b_neg = (func3[1:0] == 2'b01) & op2[XLEN-1];
    assign w_a_mag = w_a_neg ? -op1 : op1;
    assign w_b_mag = w_b_neg ? -op2 : op2;

    // Multiplier lives in the low half of r_prod and is consumed LSB first.
    // The carry out of the upper-half add shifts back in at the top.
    assign w_sum   = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
    assign w_step  = {w_sum, r_prod[XLEN-1:1]};
    assign w_fixed = r_neg ? -r_prod : r_prod;
    assign w_mul_out = r_hi ? r_prod[2*XLEN-1:XLEN] : r_prod[XLEN-1:0];

    assign in_ready = rst_n & ~flush &
                      ((r_state == S_IDLE) | ((r_state == S_HOLD) & out_ready));
    assign w_accept = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_fix_ph       <= 1'b0;
            r_neg          <= 1'b0;
            r_hi           <= 1'b0;
            r_mcand        <= '0;
            r_prod         <= '0;
            r_out_valid    <= 1'b0;
            r_branch_taken <= 1'b0;
            r_illegal      <= 1'b0;
            r_alu_res      <= '0;
            r_jump_targ    <= '0;
        end else if (flush) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
            r_fix_ph    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_HOLD: begin
                    if (w_accept) begin
                        if (w_mul_legal) begin
                            // Result registers keep the old values until the product lands.
                            r_state     <= S_MUL;
                            r_out_valid <= 1'b0;
                            r_cnt       <= '0;
                            r_mcand     <= w_a_mag;
                            r_prod      <= {{XLEN{1'b0}}, w_b_mag};
                            r_neg       <= w_a_neg ^ w_b_neg;
                            r_hi        <= func3[1:0] != 2'b00;
                        end else begin
                            r_state        <= S_HOLD;
                            r_out_valid    <= 1'b1;
                            r_alu_res      <= w_res;
                            r_jump_targ    <= w_targ;
                            r_branch_taken <= w_take;
                            r_illegal      <= w_illegal;
                        end
                    end else if ((r_state == S_HOLD) && out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                S_MUL: begin
                    r_prod <= w_step;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == '1) begin
                        r_state  <= S_FIX;
                        r_fix_ph <= 1'b0;
                    end
                end
                S_FIX: begin
                    // Two edges: negate the full product, then select the half,
                    // keeping the 2*XLEN negate and the output mux in separate cycles.
                    if (!r_fix_ph) begin
                        r_prod   <= w_fixed;
                        r_fix_ph <= 1'b1;
                    end else begin
                        r_fix_ph       <= 1'b0;
                        r_state        <= S_HOLD;
                        r_out_valid    <= 1'b1;
                        r_alu_res      <= w_mul_out;
                        r_jump_targ    <= '0;
                        r_branch_taken <= 1'b0;
                        r_illegal      <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_valid    = r_out_valid;
    assign alu_res      = r_alu_res;
    assign jump_targ    = r_jump_targ;
    assign branch_taken = r_branch_taken;
    assign out_illegal  = r_illegal;

endmodule

// File: tb/tb_r200ex_seq.sv
module tb_r200ex_seq;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_valid2, out_ready;
    logic [31:0] op1, op2, pc, imm;
    logic [2:0]  func3;
    logic        alu_cont, is_branch, is_jal, is_jalr, is_mul;
    logic        in_ready, out_valid, branch_taken, out_illegal;
    logic [31:0] alu_res, jump_targ;
    logic        n_in_ready, n_out_valid, n_branch_taken, n_out_illegal;
    logic [31:0] n_alu_res, n_jump_targ;

    always #5 clk = ~clk;

    r200ex_seq #(.XLEN(32), .MUL_EN(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op1(op1), .op2(op2), .pc(pc), .imm(imm), .func3(func3), .alu_cont(alu_cont),
        .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr), .is_mul(is_mul),
        .out_valid(out_valid), .out_ready(out_ready), .alu_res(alu_res),
        .branch_taken(branch_taken), .jump_targ(jump_targ), .out_illegal(out_illegal)
    );

    r200ex_seq #(.XLEN(32), .MUL_EN(0)) u_nomul (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid2), .in_ready(n_in_ready),
        .op1(op1), .op2(op2), .pc(pc), .imm(imm), .func3(func3), .alu_cont(alu_cont),
        .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr), .is_mul(is_mul),
        .out_valid(n_out_valid), .out_ready(out_ready), .alu_res(n_alu_res),
        .branch_taken(n_branch_taken), .jump_targ(n_jump_targ), .out_illegal(n_out_illegal)
    );

    typedef struct {
        logic [31:0] op1, op2, pc, imm;
        logic [2:0]  f3;
        logic        cont, br, jal, jalr, mul;
        logic [31:0] e_res, e_targ;
        logic        e_take, e_ill;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] a, b, p, i, input logic [2:0] f3,
                                input logic cont, br, jal, jalr, mul,
                                input logic [31:0] e_res, e_targ, input logic e_take, e_ill);
        vec_t v;
        v.op1 = a; v.op2 = b; v.pc = p; v.imm = i; v.f3 = f3;
        v.cont = cont; v.br = br; v.jal = jal; v.jalr = jalr; v.mul = mul;
        v.e_res = e_res; v.e_targ = e_targ; v.e_take = e_take; v.e_ill = e_ill;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        op1 = v.op1; op2 = v.op2; pc = v.pc; imm = v.imm; func3 = v.f3;
        alu_cont = v.cont; is_branch = v.br; is_jal = v.jal; is_jalr = v.jalr; is_mul = v.mul;
    endtask

    task automatic check_out(input int idx, input vec_t v);
        chk($sformatf("vec%0d_valid", idx), {31'b0, out_valid}, 32'd1);
        chk($sformatf("vec%0d_res", idx), alu_res, v.e_res);
        chk($sformatf("vec%0d_targ", idx), jump_targ, v.e_targ);
        chk($sformatf("vec%0d_taken", idx), {31'b0, branch_taken}, {31'b0, v.e_take});
        chk($sformatf("vec%0d_illegal", idx), {31'b0, out_illegal}, {31'b0, v.e_ill});
    endtask

    // Called just after a rising edge with the DUT idle; returns just after
    // the edge that consumes the product.
    task automatic do_mul(input string nm, input logic [31:0] a, b, input logic [2:0] f3,
                          input logic [31:0] e);
        int   lat;
        logic busy_ok;
        drive(mk(a, b, 32'h0, 32'h0, f3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0));
        in_valid = 1'b1;
        @(negedge clk);
        chk({nm, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        busy_ok = 1'b1;
        while (lat < 60) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid) break;
            if (in_ready) busy_ok = 1'b0;
        end
        chk({nm, "_latency"}, lat, 32'd34);
        chk({nm, "_busy"}, {31'b0, busy_ok}, 32'd1);
        chk({nm, "_res"}, alu_res, e);
        chk({nm, "_illegal"}, {31'b0, out_illegal}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    vec_t vecs[17];
    logic seen;

    initial begin
        vecs[0]  = mk(32'd5, 32'd3, 0, 0, 3'b000, 1, 0, 0, 0, 0, 32'd2, 0, 0, 0);
        vecs[1]  = mk(32'hFFFFFFFF, 32'd1, 0, 0, 3'b000, 0, 0, 0, 0, 0, 32'd0, 0, 0, 0);
        vecs[2]  = mk(32'h80000000, 32'd4, 0, 0, 3'b101, 1, 0, 0, 0, 0, 32'hF8000000, 0, 0, 0);
        vecs[3]  = mk(32'h80000000, 32'd4, 0, 0, 3'b101, 0, 0, 0, 0, 0, 32'h08000000, 0, 0, 0);
        vecs[4]  = mk(32'd1, 32'hFFFFFFFF, 0, 0, 3'b011, 0, 0, 0, 0, 0, 32'd1, 0, 0, 0);
        vecs[5]  = mk(32'd1, 32'hFFFFFFFF, 0, 0, 3'b010, 0, 0, 0, 0, 0, 32'd0, 0, 0, 0);
        vecs[6]  = mk(32'd1, 32'h3F, 0, 0, 3'b001, 0, 0, 0, 0, 0, 32'h80000000, 0, 0, 0);
        vecs[7]  = mk(32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 3'b100, 0, 0, 0, 0, 0, 32'h0FF00FF0, 0, 0, 0);
        vecs[8]  = mk(32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 3'b111, 0, 0, 0, 0, 0, 32'hF000F000, 0, 0, 0);
        vecs[9]  = mk(32'hFFFFFFFF, 32'd1, 32'h100, 32'h20, 3'b100, 0, 1, 0, 0, 0, 32'd0, 32'h120, 1, 0);
        vecs[10] = mk(32'hFFFFFFFF, 32'd1, 32'h100, 32'h20, 3'b101, 0, 1, 0, 0, 0, 32'd0, 32'h120, 0, 0);
        vecs[11] = mk(32'd7, 32'd7, 32'h200, 32'hFFFFFFF0, 3'b000, 0, 1, 0, 0, 0, 32'd0, 32'h1F0, 1, 0);
        vecs[12] = mk(32'hFFFFFFFF, 32'd1, 32'h40, 32'h8, 3'b110, 0, 1, 0, 0, 0, 32'd0, 32'h48, 0, 0);
        vecs[13] = mk(32'd0, 32'd0, 32'h1000, 32'h40, 3'b000, 0, 0, 1, 0, 0, 32'h1004, 32'h1040, 1, 0);
        vecs[14] = mk(32'h203, 32'd0, 32'h300, 32'h0, 3'b000, 0, 0, 0, 1, 0, 32'h304, 32'h202, 1, 0);
        vecs[15] = mk(32'd1, 32'd2, 32'h100, 32'h20, 3'b010, 0, 1, 0, 0, 0, 32'd0, 32'd0, 0, 1);
        vecs[16] = mk(32'd7, 32'd6, 0, 0, 3'b100, 0, 0, 0, 0, 1, 32'd0, 32'd0, 0, 1);

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0; out_ready = 1'b1;
        drive(mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_alu_res", alu_res, 32'd0);
        chk("rst_jump_targ", jump_targ, 32'd0);
        chk("rst_taken", {31'b0, branch_taken}, 32'd0);
        chk("rst_illegal", {31'b0, out_illegal}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // Back-to-back single-cycle ops with out_ready held high.
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i]);
            in_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("vec%0d_in_ready", i), {31'b0, in_ready}, 32'd1);
            if (i > 0) check_out(i - 1, vecs[i - 1]);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check_out(16, vecs[16]);
        @(posedge clk); #1;

        do_mul("mulh_m1", 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b001, 32'h0);
        do_mul("mulhu_m1", 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b011, 32'hFFFFFFFE);
        do_mul("mulhsu", 32'hFFFFFFFE, 32'd3, 3'b010, 32'hFFFFFFFF);
        do_mul("mul_7x6", 32'd7, 32'd6, 3'b000, 32'd42);
        do_mul("mulh_min", 32'h80000000, 32'h80000000, 3'b001, 32'h40000000);

        // Backpressure: result held, next op waits, then consume+accept together.
        drive(mk(32'd10, 32'd20, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        chk("bp_first_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        drive(mk(32'd9, 32'd4, 0, 0, 3'b000, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_valid", k), {31'b0, out_valid}, 32'd1);
            chk($sformatf("bp%0d_res", k), alu_res, 32'd30);
            chk($sformatf("bp%0d_in_ready", k), {31'b0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_next_valid", {31'b0, out_valid}, 32'd1);
        chk("bp_next_res", alu_res, 32'd5);
        @(posedge clk); #1;

        // Flush together with out_ready in HOLD: flush wins.
        drive(mk(32'd2, 32'd2, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("hold_flush_valid", {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;

        // Flush mid-multiply; the op offered during flush must be dropped.
        drive(mk(32'd7, 32'd6, 0, 0, 3'b000, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        drive(mk(32'd100, 32'd23, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        in_valid = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_ready_after", {31'b0, in_ready}, 32'd1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("flush_no_result", {31'b0, seen}, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_flush_valid", {31'b0, out_valid}, 32'd1);
        chk("post_flush_res", alu_res, 32'd123);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a multiply.
        drive(mk(32'd7, 32'd6, 0, 0, 3'b000, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("mul_outputs_stable", alu_res, 32'd123);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_res", alu_res, 32'd0);
        chk("arst_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("arst_no_result", {31'b0, seen}, 32'd0);
        @(posedge clk); #1;

        // MUL_EN=0 build: a plain MUL is illegal with single-cycle latency.
        drive(mk(32'd7, 32'd6, 0, 0, 3'b000, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        in_valid2 = 1'b1;
        @(negedge clk);
        chk("nomul_in_ready", {31'b0, n_in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        @(negedge clk);
        chk("nomul_valid", {31'b0, n_out_valid}, 32'd1);
        chk("nomul_illegal", {31'b0, n_out_illegal}, 32'd1);
        chk("nomul_res", n_alu_res, 32'd0);
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/r200ex_seq.md
# r200ex_seq

Parametrised, handshaked execute stage for the r200 core. Takes decoded RV32I/M operands and produces a registered ALU result, branch decision and jump target for memory/writeback. Single-cycle for base ALU/branch/jump ops; iterative shift-add multiplier for MUL/MULH/MULHSU/MULHU. Valid/ready on both sides plus a flush input for pipeline redirect.

## Interface
- XLEN, 32, datapath width (power of two, ≥8)
- MUL_EN, 1, 1 = multiplier present; 0 = every is_mul op is illegal
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of in-flight/held op
- in_valid  in  1  operation offered
- in_ready  out  1  stage accepts when in_valid & in_ready
- op1, op2  in  XLEN  rs1/rs2 operand values
- pc, imm  in  XLEN  instruction address, sign-extended immediate
- func3  in  3  instruction [14:12]
- alu_cont  in  1  instruction bit 30: SUB / SRA select
- is_branch, is_jal, is_jalr, is_mul  in  1  op class (one-hot or all zero = ALU op)
- out_valid  out  1  result held
- out_ready  in  1  downstream consumes when out_valid & out_ready
- alu_res  out  XLEN  ALU/multiply result, or pc+4 for jal/jalr
- branch_taken  out  1  redirect required (taken branch, or any jal/jalr)
- jump_targ  out  XLEN  redirect target
- out_illegal  out  1  unsupported op; alu_res = 0

## Operation
- ALU func3: 000 add (alu_cont=1 sub), 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl (alu_cont=1 sra), 110 or, 111 and. Shift amount = op2[log2(XLEN)-1:0]. All arithmetic mod 2^XLEN.
- Branch func3: 000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu; 010/011 → out_illegal=1, not taken. jump_targ = pc+imm; alu_res = 0.
- jal: jump_targ = pc+imm; jalr: jump_targ = (op1+imm) & ~1; both alu_res = pc+4, branch_taken=1.
- Multiply func3: 000 MUL (low XLEN of product), 001 MULH (s×s high), 010 MULHSU (op1 signed, op2 unsigned, high), 011 MULHU (u×u high). func3[2]=1 (div/rem) or MUL_EN=0 → single-cycle illegal result.
- Multiplier: operands converted to magnitudes, sign of product recorded; one shift-add step per cycle over 2·XLEN accumulator; final cycle conditionally two's-complement negates 2·XLEN product and selects half.
- FSM: IDLE → (accept is_mul legal) → MUL, counter 0..XLEN-1 → FIX → HOLD; IDLE → (accept other) → HOLD; HOLD → (out_ready) → IDLE, or directly accepts next op when in_ready.
- in_ready = rst_n & ~flush & (state IDLE, or HOLD with out_ready).
- flush: any state → IDLE next edge, out_valid=0, counter cleared; an in_valid in the flush cycle is not accepted.
- Reset: state IDLE, out_valid=0, alu_res=0, jump_targ=0, branch_taken=0, out_illegal=0, counter=0; in_ready=0 while rst_n low. Reset mid-multiply discards it.
- Outputs change only on the edge that loads a new result; stable while out_valid & ~out_ready.

## Timing
- Non-multiply: accepted at edge N → out_valid and results valid after edge N+1 (1-cycle latency); back-to-back throughput 1/cycle with out_ready=1.
- Multiply: accepted at edge N → MUL for XLEN edges → FIX → out_valid after edge N+XLEN+2. in_ready=0 throughout.
- Backpressure: out_valid held, in_ready=0, no input accepted until out_ready.
- Simultaneous out_ready and in_valid in HOLD: old result consumed and new op accepted on the same edge; no bubble.
- Simultaneous flush and out_ready: flush wins; out_valid drops.

## Test plan
- Reset then ALU: op1=5, op2=3, func3=000, alu_cont=1 → alu_res=2 one cycle after accept; sra 0x80000000>>4 → 0xF8000000; sltu 1<0xFFFFFFFF → 1.
- Branch/jump: blt op1=-1, op2=1, pc=0x100, imm=0x20 → branch_taken=1, jump_targ=0x120; jalr op1=0x203, imm=0 → jump_targ=0x202, alu_res=pc+4.
- Multiply (XLEN=32): MULH 0xFFFFFFFF×0xFFFFFFFF → 0; MULHU same → 0xFFFFFFFE; MULHSU -2×3 → 0xFFFFFFFF; MUL 7×6 → 42; out_valid exactly 34 cycles after accept.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 → result stable, no accept; release → consume + accept on same edge.
- Flush mid-multiply at cycle 10 → out_valid never asserts, in_ready=1 next cycle, following add returns correct result; async reset mid-op → all outputs 0 immediately.
- Illegal: func3=100 with is_mul, and MUL_EN=0 build with MUL → out_illegal=1, alu_res=0, 1-cycle latency.
